// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master among N requesters.
// Optional WAIT watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_master_arbiter #(
   parameter int unsigned N      = 4,
   parameter int unsigned W_DAT  = 32,
   parameter int unsigned W_CNT  = 8,
   parameter int unsigned GAP    = 4
`ifdef SPI_ARB_TIMEOUT_EN
   ,
   parameter int unsigned TO_CYC = 4096
`endif
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [N-1:0]       i_req,
   input  logic [N*W_DAT-1:0] i_req_dat,
   input  logic [N*W_CNT-1:0] i_req_bit_cnt,
   input  logic [N*W_CNT-1:0] i_req_clk_div,
   input  logic [N*W_CNT-1:0] i_req_mosi_cnt,
   input  logic [N*5-1:0]     i_req_mode,
   output logic [N-1:0]       o_ack,
   output logic [W_DAT-1:0]   o_rsp_dat,
   output logic               o_rsp_err,
   output logic [2:0]         o_sel,
   output logic               o_busy,
   output logic [W_DAT-1:0]   o_m_dat_mosi,
   output logic [W_CNT-1:0]   o_m_bit_cnt,
   output logic [W_CNT-1:0]   o_m_clk_div,
   output logic [W_CNT-1:0]   o_m_mosi_cnt,
   output logic [2:0]         o_m_miso_ltn,
   output logic               o_m_cpol,
   output logic               o_m_cpha,
   output logic               o_m_f_snd,
   input  logic               i_m_f_fin,
   input  logic [W_DAT-1:0]   i_m_dat_miso
);

   localparam int unsigned GW = (GAP < 1) ? 1 : $clog2(GAP + 1);

   typedef enum logic [2:0] {StIdle, StLoad, StSend, StWait, StDone, StGap} state_t;

   state_t           r_state, w_state_nxt;
   logic [2:0]       r_ptr, r_sel;
   logic [GW-1:0]    r_gap;
   logic [N-1:0]     r_ack, w_sel_oh;
   logic [W_DAT-1:0] r_rsp_dat;
   logic             r_snd;
   logic             w_found, w_to_hit;
   logic [2:0]       w_win;
   logic [3:0]       w_cand;
   logic [W_DAT-1:0] w_dat;
   logic [W_CNT-1:0] w_bit_cnt, w_clk_div, w_mosi_cnt;
   logic [4:0]       w_mode;

   // Search starts just above the last owner so it has lowest priority next round
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_cand  = '0;
      for (int k = 1; k <= int'(N); k++) begin
         w_cand = {1'b0, r_ptr} + 4'(k);
         if (w_cand >= 4'(N)) w_cand = w_cand - 4'(N);
         for (int i = 0; i < int'(N); i++) begin
            if (!w_found && (w_cand == 4'(i)) && i_req[i]) begin
               w_found = 1'b1;
               w_win   = 3'(i);
            end
         end
      end
   end

   always_comb begin
      w_dat      = '0;
      w_bit_cnt  = '0;
      w_clk_div  = '0;
      w_mosi_cnt = '0;
      w_mode     = '0;
      w_sel_oh   = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (w_win == 3'(i)) begin
            w_dat      = i_req_dat[i*W_DAT +: W_DAT];
            w_bit_cnt  = i_req_bit_cnt[i*W_CNT +: W_CNT];
            w_clk_div  = i_req_clk_div[i*W_CNT +: W_CNT];
            w_mosi_cnt = i_req_mosi_cnt[i*W_CNT +: W_CNT];
            w_mode     = i_req_mode[i*5 +: 5];
         end
         w_sel_oh[i] = (r_sel == 3'(i));
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         StIdle:  if (w_found) w_state_nxt = StLoad;
         StLoad:  w_state_nxt = StSend;
         StSend:  w_state_nxt = StWait;
         StWait:  if (i_m_f_fin || w_to_hit) w_state_nxt = StDone;
         StDone:  w_state_nxt = StGap;
         StGap:   if (r_gap <= GW'(1)) w_state_nxt = StIdle;
         default: w_state_nxt = StIdle;
      endcase
   end

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TO_CYC + 1);
   logic [TW-1:0] r_to;
   logic          r_err;

   always_ff @(posedge i_clk) begin
      if (i_rst || (r_state != StWait)) r_to <= '0;
      else                              r_to <= r_to + 1'b1;
   end

   assign w_to_hit  = (r_state == StWait) && (r_to == TW'(TO_CYC));
   assign o_rsp_err = r_err;
`else
   assign w_to_hit  = 1'b0;
   assign o_rsp_err = 1'b0;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_ptr        <= 3'(N - 1);
         r_sel        <= '0;
         r_gap        <= '0;
         r_ack        <= '0;
         r_rsp_dat    <= '0;
         r_snd        <= 1'b0;
         o_m_dat_mosi <= '0;
         o_m_bit_cnt  <= '0;
         o_m_clk_div  <= '0;
         o_m_mosi_cnt <= '0;
         o_m_miso_ltn <= '0;
         o_m_cpol     <= 1'b0;
         o_m_cpha     <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
         r_err        <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_ack   <= '0;
         r_snd   <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_found) begin
                  r_sel        <= w_win;
                  r_ptr        <= w_win;
                  o_m_dat_mosi <= w_dat;
                  o_m_bit_cnt  <= w_bit_cnt;
                  o_m_clk_div  <= w_clk_div;
                  o_m_mosi_cnt <= w_mosi_cnt;
                  o_m_miso_ltn <= w_mode[4:2];
                  o_m_cpol     <= w_mode[1];
                  o_m_cpha     <= w_mode[0];
               end
            end
            StLoad: r_snd <= 1'b1;
            StWait: begin
               // A finish coinciding with the watchdog limit is a normal completion
               if (i_m_f_fin) begin
                  r_ack     <= w_sel_oh;
                  r_rsp_dat <= i_m_dat_miso;
`ifdef SPI_ARB_TIMEOUT_EN
                  r_err     <= 1'b0;
`endif
               end else if (w_to_hit) begin
                  r_ack     <= w_sel_oh;
                  r_rsp_dat <= '1;
`ifdef SPI_ARB_TIMEOUT_EN
                  r_err     <= 1'b1;
`endif
               end
            end
            StDone:  r_gap <= GW'(GAP);
            StGap:   r_gap <= r_gap - 1'b1;
            default: ;
         endcase
      end
   end

   assign o_ack     = r_ack;
   assign o_rsp_dat = r_rsp_dat;
   assign o_sel     = r_sel;
   assign o_busy    = (r_state != StIdle);
   assign o_m_f_snd = r_snd;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Self-checking bench for spi_master_arbiter with a behavioural round-robin model.
module tb_spi_master_arbiter;
   localparam int N = 4, W_DAT = 32, W_CNT = 8, GAP = 4;
`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TO = 64;
`endif
   localparam int MW = W_DAT + 3*W_CNT + 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst, fin;
   logic [N-1:0]       req, ack;
   logic [N*W_DAT-1:0] req_dat;
   logic [N*W_CNT-1:0] req_bit_cnt, req_clk_div, req_mosi_cnt;
   logic [N*5-1:0]     req_mode;
   logic [W_DAT-1:0]   rsp_dat, m_dat_mosi, miso;
   logic               rsp_err, busy, m_cpol, m_cpha, m_f_snd;
   logic [2:0]         sel, m_miso_ltn;
   logic [W_CNT-1:0]   m_bit_cnt, m_clk_div, m_mosi_cnt;
   logic [MW-1:0]      mstate;

   logic [W_DAT-1:0] dat_a [N];
   logic [W_CNT-1:0] bcnt_a [N], div_a [N], mcnt_a [N];
   logic [4:0]       mode_a [N];

   int checks = 0, errors = 0;
   int m_ptr;

   always_comb begin
      req_dat = '0; req_bit_cnt = '0; req_clk_div = '0; req_mosi_cnt = '0; req_mode = '0;
      for (int i = 0; i < N; i++) begin
         req_dat[i*W_DAT +: W_DAT]      = dat_a[i];
         req_bit_cnt[i*W_CNT +: W_CNT]  = bcnt_a[i];
         req_clk_div[i*W_CNT +: W_CNT]  = div_a[i];
         req_mosi_cnt[i*W_CNT +: W_CNT] = mcnt_a[i];
         req_mode[i*5 +: 5]             = mode_a[i];
      end
   end

   assign mstate = {m_dat_mosi, m_bit_cnt, m_clk_div, m_mosi_cnt, m_miso_ltn, m_cpol, m_cpha};

   spi_master_arbiter #(
      .N(N), .W_DAT(W_DAT), .W_CNT(W_CNT), .GAP(GAP)
`ifdef SPI_ARB_TIMEOUT_EN
      , .TO_CYC(TO)
`endif
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_dat(req_dat),
      .i_req_bit_cnt(req_bit_cnt), .i_req_clk_div(req_clk_div),
      .i_req_mosi_cnt(req_mosi_cnt), .i_req_mode(req_mode),
      .o_ack(ack), .o_rsp_dat(rsp_dat), .o_rsp_err(rsp_err), .o_sel(sel), .o_busy(busy),
      .o_m_dat_mosi(m_dat_mosi), .o_m_bit_cnt(m_bit_cnt), .o_m_clk_div(m_clk_div),
      .o_m_mosi_cnt(m_mosi_cnt), .o_m_miso_ltn(m_miso_ltn), .o_m_cpol(m_cpol),
      .o_m_cpha(m_cpha), .o_m_f_snd(m_f_snd), .i_m_f_fin(fin), .i_m_dat_miso(miso)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   // Reference rule: first requester above the last owner, wrapping mod N
   function automatic int exp_winner(input logic [N-1:0] r, input int ptr);
      for (int k = 1; k <= N; k++) begin
         if (r[(ptr + k) % N]) return (ptr + k) % N;
      end
      return 0;
   endfunction

   function automatic logic [MW-1:0] exp_cfg(input int w);
      return {dat_a[w], bcnt_a[w], div_a[w], mcnt_a[w], mode_a[w]};
   endfunction

   task automatic randomize_slot(input int i);
      dat_a[i]  = $urandom;
      bcnt_a[i] = W_CNT'($urandom);
      div_a[i]  = W_CNT'($urandom);
      mcnt_a[i] = W_CNT'($urandom);
      mode_a[i] = 5'($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b1; req = '0; fin = 1'b0;
      tick(); tick();
      rst = 1'b0;
      m_ptr = N - 1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < N; i++) randomize_slot(i);
      rst = 1'b1; req = '0; fin = 1'b1; miso = $urandom;
      tick(); tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (ack !== '0) begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
      checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", sel); end
      checks++; if ({rsp_dat, rsp_err, m_f_snd} !== '0) begin
         errors++; $display("FAIL reset_rsp got %h/%b/%b want 0", rsp_dat, rsp_err, m_f_snd);
      end
      checks++; if (mstate !== '0) begin errors++; $display("FAIL reset_m got %h want 0", mstate); end
      rst = 1'b0;  // stale finish still high after reset release
      tick();
      fin = 1'b0;
      tick();
      checks++; if ({busy, ack} !== '0) begin
         errors++; $display("FAIL stale_fin got busy=%b ack=%b want 0", busy, ack);
      end
      m_ptr = N - 1;
   endtask

   task automatic test_single();
      for (int i = 0; i < N; i++) randomize_slot(i);
      dat_a[2] = 32'hA5A5_0001;
      req = 4'b0100;
      tick();
      checks++; if (sel !== 3'd2) begin errors++; $display("FAIL single_sel got %0d want 2", sel); end
      checks++; if (mstate !== exp_cfg(2)) begin
         errors++; $display("FAIL single_cfg got %h want %h", mstate, exp_cfg(2));
      end
      checks++; if (m_f_snd !== 1'b0) begin errors++; $display("FAIL single_snd_early got 1 want 0"); end
      tick();
      checks++; if (m_f_snd !== 1'b1) begin errors++; $display("FAIL single_snd got 0 want 1"); end
      m_ptr = 2;
      repeat (1 + $urandom_range(0, 4)) tick();
      fin = 1'b1; miso = 32'h1234_5678;
      tick();
      fin = 1'b0; miso = $urandom; req = '0;
      checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL single_ack got %b want 0100", ack); end
      checks++; if (rsp_dat !== 32'h1234_5678) begin
         errors++; $display("FAIL single_rsp got %h want 12345678", rsp_dat);
      end
      checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL single_err got 1 want 0"); end
      tick();
      checks++; if ({ack, rsp_dat} !== {4'b0000, 32'h1234_5678}) begin
         errors++; $display("FAIL single_hold got %b/%h want 0000/12345678", ack, rsp_dat);
      end
      repeat (GAP) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy=1 want 0"); end
   endtask

   task automatic test_round_robin();
      int n, w;
      logic [MW-1:0] snap;
      logic [W_DAT-1:0] rd;
      do_reset();
      for (int i = 0; i < N; i++) randomize_slot(i);
      req = '1;
      for (int t = 0; t < 2*N + 1; t++) begin
         n = 0;
         while (m_f_snd !== 1'b1 && n < 60) begin tick(); n++; end
         checks++; if (n >= 60) begin errors++; $display("FAIL rr_timeout got no snd want snd"); end
         w = exp_winner(req, m_ptr);
         m_ptr = w;
         if (t > 0) begin
            checks++; if (n !== GAP + 3) begin
               errors++; $display("FAIL rr_spacing got %0d want %0d", n, GAP + 3);
            end
         end
         checks++; if (sel !== 3'(w)) begin errors++; $display("FAIL rr_sel got %0d want %0d", sel, w); end
         checks++; if (mstate !== exp_cfg(w)) begin
            errors++; $display("FAIL rr_cfg got %h want %h", mstate, exp_cfg(w));
         end
         snap = exp_cfg(w);
         randomize_slot(w);  // later input changes must not leak into m_*
         repeat (1 + $urandom_range(0, 4)) begin
            tick();
            checks++; if (mstate !== snap) begin
               errors++; $display("FAIL rr_hold got %h want %h", mstate, snap);
            end
         end
         rd = $urandom;
         fin = 1'b1; miso = rd;
         tick();
         fin = 1'b0; miso = $urandom;
         checks++; if (ack !== N'(1 << w)) begin
            errors++; $display("FAIL rr_ack got %b want %b", ack, N'(1 << w));
         end
         checks++; if (rsp_dat !== rd) begin errors++; $display("FAIL rr_rsp got %h want %h", rsp_dat, rd); end
      end
      req = '0;
      repeat (GAP + 1) tick();
   endtask

   task automatic test_modes();
      int n, w;
      logic [4:0] cur;
      do_reset();
      for (int i = 0; i < N; i++) randomize_slot(i);
      mode_a[1] = 5'b011_1_0;
      mode_a[3] = 5'b000_0_1;
      req = 4'b1010;
      cur = '0;
      for (int t = 0; t < 2; t++) begin
         n = 0;
         while (busy !== 1'b1 && n < 20) begin
            checks++; if ({m_miso_ltn, m_cpol, m_cpha} !== cur) begin
               errors++; $display("FAIL mode_idle got %b want %b", {m_miso_ltn, m_cpol, m_cpha}, cur);
            end
            tick(); n++;
         end
         w = exp_winner(req, m_ptr);
         m_ptr = w;
         cur = mode_a[w];
         checks++; if (sel !== 3'(w)) begin errors++; $display("FAIL mode_sel got %0d want %0d", sel, w); end
         n = 0;
         while (ack === '0 && n < 20) begin
            checks++; if ({m_miso_ltn, m_cpol, m_cpha} !== cur) begin
               errors++; $display("FAIL mode_txn got %b want %b", {m_miso_ltn, m_cpol, m_cpha}, cur);
            end
            fin = (n == 4);
            tick(); n++;
         end
         fin = 1'b0;
         checks++; if (ack !== N'(1 << w)) begin
            errors++; $display("FAIL mode_ack got %b want %b", ack, N'(1 << w));
         end
         if (t == 1) req = '0;
         n = 0;
         while (busy === 1'b1 && n < 20) begin
            checks++; if ({m_miso_ltn, m_cpol, m_cpha} !== cur) begin
               errors++; $display("FAIL mode_gap got %b want %b", {m_miso_ltn, m_cpol, m_cpha}, cur);
            end
            tick(); n++;
         end
      end
   endtask

   task automatic test_hazards();
      int n;
      do_reset();
      randomize_slot(0);
      req = 4'b0001;
      tick();
      checks++; if ({busy, sel} !== {1'b1, 3'd0}) begin
         errors++; $display("FAIL drop_grant got %b/%0d want 1/0", busy, sel);
      end
      req = '0;
      n = 0;
      while (m_f_snd !== 1'b1 && n < 20) begin tick(); n++; end
      tick();
      fin = 1'b1; miso = $urandom;
      tick();
      fin = 1'b0;
      checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL drop_ack got %b want 0001", ack); end
      repeat (GAP + 1) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle got 1 want 0"); end
      fin = 1'b1;
      tick();
      fin = 1'b0;
      checks++; if ({busy, ack} !== '0) begin
         errors++; $display("FAIL stray_fin got busy=%b ack=%b want 0", busy, ack);
      end
      tick();
      checks++; if ({busy, ack, m_f_snd} !== '0) begin
         errors++; $display("FAIL stray_fin2 got %b/%b/%b want 0", busy, ack, m_f_snd);
      end
   endtask

   task automatic test_rst_wait();
      int n;
      logic [W_DAT-1:0] rd;
      do_reset();
      for (int i = 0; i < N; i++) randomize_slot(i);
      req = 4'b0100;
      n = 0;
      while (m_f_snd !== 1'b1 && n < 20) begin tick(); n++; end
      tick(); tick();
      rst = 1'b1; req = '0;
      tick();
      checks++; if ({busy, ack} !== '0) begin
         errors++; $display("FAIL rstw_busy got busy=%b ack=%b want 0", busy, ack);
      end
      checks++; if ({mstate, sel} !== '0) begin
         errors++; $display("FAIL rstw_regs got %h/%0d want 0", mstate, sel);
      end
      rst = 1'b0; m_ptr = N - 1;
      fin = 1'b1; miso = $urandom;
      tick();
      fin = 1'b0;
      tick();
      checks++; if ({busy, ack} !== '0) begin
         errors++; $display("FAIL rstw_late_fin got busy=%b ack=%b want 0", busy, ack);
      end
      req = 4'b0010;
      tick();
      checks++; if ({busy, sel} !== {1'b1, 3'(exp_winner(req, m_ptr))}) begin
         errors++; $display("FAIL rstw_regrant got %b/%0d want 1/1", busy, sel);
      end
      n = 0;
      while (m_f_snd !== 1'b1 && n < 20) begin tick(); n++; end
      checks++; if (m_dat_mosi !== dat_a[1]) begin
         errors++; $display("FAIL rstw_mosi got %h want %h", m_dat_mosi, dat_a[1]);
      end
      tick();
      rd = $urandom;
      fin = 1'b1; miso = rd;
      tick();
      fin = 1'b0; req = '0;
      checks++; if ({ack, rsp_dat} !== {4'b0010, rd}) begin
         errors++; $display("FAIL rstw_ack got %b/%h want 0010/%h", ack, rsp_dat, rd);
      end
      repeat (GAP + 1) tick();
   endtask

`ifdef SPI_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      do_reset();
      randomize_slot(0);
      req = 4'b0001;
      n = 0;
      while (m_f_snd !== 1'b1 && n < 20) begin tick(); n++; end
      n = 0;
      while (ack === '0 && n < 4*TO) begin tick(); n++; end
      req = '0;
      checks++; if (n !== TO + 2) begin errors++; $display("FAIL to_latency got %0d want %0d", n, TO + 2); end
      checks++; if ({ack, rsp_err, rsp_dat} !== {4'b0001, 1'b1, 32'hFFFF_FFFF}) begin
         errors++; $display("FAIL to_rsp got %b/%b/%h want 0001/1/ffffffff", ack, rsp_err, rsp_dat);
      end
      repeat (GAP + 1) tick();
   endtask
`endif

   initial begin
      rst = 1'b1; req = '0; fin = 1'b0; miso = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_modes();
      test_hazards();
      test_rst_wait();
`ifdef SPI_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
